// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM encoding,
// default widths and instruction field positions.
package fetch_unit_pkg;

  localparam int PC_W_DEF        = 16;
  localparam int IR_W_DEF        = 32;
  localparam int ACK_TIMEOUT_DEF = 15;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;

  typedef enum logic [3:0] {
    NOOP = 4'h0,
    LOD  = 4'h1,
    STR  = 4'h2,
    ADD  = 4'h3,
    SUB  = 4'h4,
    AND  = 4'h5,
    OR   = 4'h6,
    XOR  = 4'h7,
    NOT  = 4'h8,
    SHL  = 4'h9,
    SHR  = 4'hA,
    CMP  = 4'hB,
    BRA  = 4'hC,
    BRZ  = 4'hD,
    BRN  = 4'hE,
    HLT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit_pc_unit.sv
// Program counter: post-fetch increment, absolute load or signed relative
// branch, all wrapping modulo 2^PC_W.
module pc_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            ld_en,
  input  logic            ld_rel,
  input  logic [PC_W-1:0] ld_val,
  input  logic            inc_en,
  input  logic [PC_W-1:0] inc_base,
  output logic [PC_W-1:0] tgt,
  output logic [PC_W-1:0] pc
);

  logic signed [PC_W-1:0] off;
  logic signed [PC_W-1:0] one;

  function automatic logic [PC_W-1:0] wrap_add(input logic [PC_W-1:0] a,
                                               input logic signed [PC_W-1:0] b);
    return PC_W'(a + $unsigned(b));
  endfunction

  assign off = ld_val;
  assign one = PC_W'(1);
  assign tgt = ld_rel ? wrap_add(pc, off) : ld_val;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc <= '0;
    end else if (inc_en) begin
      pc <= wrap_add(inc_base, one);
    end else if (ld_en) begin
      pc <= tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues a memory read for the next instruction, captures
// it into ir with opcode/mm fields, and flags a sticky error on ack timeout.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            fetch_req,
  input  logic            br_load,
  input  logic            br_rel,
  input  logic [PC_W-1:0] br_val,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_data,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [PC_W-1:0] pc,
  output logic            fetch_done,
  output logic            busy,
  output logic            fetch_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [PC_W-1:0]   br_tgt;
  logic [PC_W-1:0]   fetch_addr;
  logic              in_idle;
  logic              take_ack;
  logic              br_only;
  logic [IR_W-1:0]   ir_p1;
  logic [3:0]        opc_p1;
  logic [3:0]        mm_p1;
  logic              vld_p1;

  assign in_idle    = (state == S_IDLE);
  assign take_ack   = (state == S_REQ) && imem_ack;
  assign br_only    = in_idle && br_load && !fetch_req;
  assign fetch_addr = br_load ? br_tgt : pc;

  pc_unit #(
    .PC_W (PC_W)
  ) u_pc (
    .clk      (clk),
    .rst_f    (rst_f),
    .ld_en    (br_only),
    .ld_rel   (br_rel),
    .ld_val   (br_val),
    .inc_en   (take_ack),
    .inc_base (imem_addr),
    .tgt      (br_tgt),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
      ir_p1     <= '0;
      opc_p1    <= '0;
      mm_p1     <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
            state     <= S_REQ;
            wait_cnt  <= '0;
            imem_addr <= fetch_addr;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_REQ: begin
          // p1: instruction word captured on the ack cycle
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            ir_p1    <= imem_data;
            opc_p1   <= imem_data[OPC_HI:OPC_LO];
            mm_p1    <= imem_data[MM_HI:MM_LO];
            vld_p1   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
              state     <= S_ERR;
              imem_req  <= 1'b0;
              fetch_err <= 1'b1;
            end
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ir         = ir_p1;
  assign opcode     = opc_p1;
  assign mm         = mm_p1;
  assign fetch_done = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch latency, branches, wrap, timeout, reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        fetch_req;
  logic        br_load;
  logic        br_rel;
  logic [15:0] br_val;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int n_chk;
  int n_fail;

  fetch_unit #(
    .PC_W        (16),
    .IR_W        (32),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .fetch_req  (fetch_req),
    .br_load    (br_load),
    .br_rel     (br_rel),
    .br_val     (br_val),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .pc         (pc),
    .fetch_done (fetch_done),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic br(input logic rel, input logic [15:0] val, input logic [15:0] exp_pc,
                    input string tag);
    br_load = 1'b1;
    br_rel  = rel;
    br_val  = val;
    cyc();
    br_load = 1'b0;
    br_rel  = 1'b0;
    chk(tag, 32'(pc), 32'(exp_pc));
  endtask

  // Fetch with ack in the first imem_req cycle.
  task automatic fetch(input logic [31:0] data, input logic [15:0] exp_addr,
                       input logic [3:0] exp_opc, input logic [3:0] exp_mm,
                       input logic [15:0] exp_pc, input string tag);
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    chk({tag, ".req"},  32'(imem_req), 32'd1);
    chk({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".done_early"}, 32'(fetch_done), 32'd0);
    imem_ack  = 1'b1;
    imem_data = data;
    cyc();
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    chk({tag, ".ir"},     ir, data);
    chk({tag, ".opcode"}, 32'(opcode), 32'(exp_opc));
    chk({tag, ".mm"},     32'(mm), 32'(exp_mm));
    chk({tag, ".pc"},     32'(pc), 32'(exp_pc));
    chk({tag, ".done"},   32'(fetch_done), 32'd1);
    chk({tag, ".req_off"}, 32'(imem_req), 32'd0);
    cyc();
    chk({tag, ".done_pulse"}, 32'(fetch_done), 32'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_f     = 1'b0;
    fetch_req = 1'b0;
    br_load   = 1'b0;
    br_rel    = 1'b0;
    br_val    = 16'h0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    cyc();
    cyc();
    chk("rst.pc",   32'(pc), 32'h0);
    chk("rst.ir",   ir, 32'h0);
    chk("rst.req",  32'(imem_req), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.err",  32'(fetch_err), 32'h0);
    chk("rst.addr", 32'(imem_addr), 32'h0);
    rst_f = 1'b1;

    // Minimum-latency fetch straight after reset
    fetch(32'h1A00_0000, 16'h0000, 4'h1, 4'hA, 16'h0001, "f0");

    // Absolute and relative branch loads in IDLE
    br(1'b0, 16'h0010, 16'h0010, "br.abs10");
    br(1'b1, 16'hFFFE, 16'h000E, "br.rel_m2");
    br(1'b0, 16'h0100, 16'h0100, "br.abs100");
    chk("br.busy", 32'(busy), 32'd0);

    // pc wrap on increment
    br(1'b0, 16'hFFFF, 16'hFFFF, "wrap.ld");
    fetch(32'hF3C0_1234, 16'hFFFF, 4'hF, 4'h3, 16'h0000, "wrap");

    // ack in IDLE has no effect
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    cyc();
    imem_ack  = 1'b0;
    chk("idle_ack.ir",   ir, 32'hF3C0_1234);
    chk("idle_ack.done", 32'(fetch_done), 32'd0);

    // fetch_req + br_load together fetch from the target
    br(1'b0, 16'h0005, 16'h0005, "fb.ld");
    fetch_req = 1'b1;
    br_load   = 1'b1;
    br_val    = 16'h0040;
    cyc();
    chk("fb.addr", 32'(imem_addr), 32'h0040);
    chk("fb.pc_hold", 32'(pc), 32'h0005);
    // fetch_req/br_load are ignored while REQ is pending
    br_val = 16'h1234;
    cyc();
    fetch_req = 1'b0;
    br_load   = 1'b0;
    chk("fb.ign_addr", 32'(imem_addr), 32'h0040);
    chk("fb.ign_pc",   32'(pc), 32'h0005);
    imem_ack  = 1'b1;
    imem_data = 32'h2B00_0007;
    cyc();
    imem_ack  = 1'b0;
    chk("fb.pc",   32'(pc), 32'h0041);
    chk("fb.ir",   ir, 32'h2B00_0007);
    chk("fb.done", 32'(fetch_done), 32'd1);

    // Ack timeout after 15 REQ cycles
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    for (int i = 1; i < 15; i++) cyc();
    chk("to.req_before", 32'(imem_req), 32'd1);
    chk("to.err_before", 32'(fetch_err), 32'd0);
    cyc();
    chk("to.err",  32'(fetch_err), 32'd1);
    chk("to.busy", 32'(busy), 32'd1);
    chk("to.req",  32'(imem_req), 32'd0);
    chk("to.pc",   32'(pc), 32'h0041);
    fetch_req = 1'b1;
    br_load   = 1'b1;
    br_val    = 16'h0777;
    imem_ack  = 1'b1;
    imem_data = 32'h5555_5555;
    cyc();
    cyc();
    fetch_req = 1'b0;
    br_load   = 1'b0;
    imem_ack  = 1'b0;
    chk("err.req",  32'(imem_req), 32'd0);
    chk("err.pc",   32'(pc), 32'h0041);
    chk("err.ir",   ir, 32'h2B00_0007);
    chk("err.done", 32'(fetch_done), 32'd0);
    chk("err.hold", 32'(fetch_err), 32'd1);
    rst_f = 1'b0;
    #1;
    chk("errrst.err",  32'(fetch_err), 32'd0);
    chk("errrst.busy", 32'(busy), 32'd0);
    chk("errrst.pc",   32'(pc), 32'h0);
    chk("errrst.ir",   ir, 32'h0);
    chk("errrst.opc",  32'(opcode), 32'h0);
    cyc();
    rst_f = 1'b1;

    // First fetch_req after deassertion is honoured
    br(1'b0, 16'h0200, 16'h0200, "r2.ld");
    fetch(32'h7E00_00AA, 16'h0200, 4'h7, 4'hE, 16'h0201, "r2");

    // Reset mid-REQ, late ack ignored
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    chk("midrst.req", 32'(imem_req), 32'd1);
    rst_f = 1'b0;
    #1;
    chk("midrst.req_clr", 32'(imem_req), 32'd0);
    cyc();
    rst_f = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'hC3C3_C3C3;
    cyc();
    imem_ack = 1'b0;
    chk("midrst.ir",   ir, 32'h0);
    chk("midrst.pc",   32'(pc), 32'h0);
    chk("midrst.done", 32'(fetch_done), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    cyc();
    chk("midrst.done2", 32'(fetch_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
